// File: rtl/fir_pkg.sv
// Shared definitions for the serial-MAC FIR engine: default sizes,
// width helpers and the controller state encoding.
package fir_pkg;

    localparam int NUM_COEF_DEF = 17;
    localparam int WC_DEF       = 18;
    localparam int WIN_DEF      = 16;

    // Ceiling log2, never below 1 so an address port always has a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Accumulator width that cannot overflow for num_coef full-scale products.
    function automatic int wacc_width(input int win, input int wc, input int num_coef);
        return win + wc + clog2(num_coef);
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        FLUSH = 2'd2
    } fir_state_t;

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer: one write port, one registered read port,
// synchronously cleared to zero on reset.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int Num_coef = NUM_COEF_DEF,
    parameter int Win      = WIN_DEF,
    localparam int Aw      = clog2(Num_coef)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [Aw-1:0]         wr_addr,
    input  logic signed [Win-1:0] wr_data,
    input  logic [Aw-1:0]         rd_addr,
    output logic signed [Win-1:0] rd_data
);

    logic signed [Win-1:0] mem [Num_coef];

    // Sample storage: clear everything on reset, otherwise write the accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < Num_coef; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read so the sample lines up with the ROM's one-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fir_serial_mac.sv
// Time-multiplexed single-MAC FIR: one output per accepted sample,
// walking the external coefficient ROM one tap per cycle.
module fir_serial_mac
    import fir_pkg::*;
#(
    parameter int Num_coef = NUM_COEF_DEF,
    parameter int Wc       = WC_DEF,
    parameter int Win      = WIN_DEF,
    localparam int Wacc    = wacc_width(Win, Wc, Num_coef),
    localparam int Aw      = clog2(Num_coef)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   din_valid,
    input  logic signed [Win-1:0]  din,
    output logic                   din_ready,
    output logic [Aw-1:0]          coef_addr,
    input  logic signed [Wc-1:0]   coef_data,
    output logic signed [Wacc-1:0] dout,
    output logic                   dout_valid
);

    localparam logic [Aw-1:0] LAST_TAP = Aw'(Num_coef - 1);
    localparam logic [Aw-1:0] N_TAPS   = Aw'(Num_coef);

    fir_state_t state, state_next;

    logic                    accept;
    logic [Aw-1:0]           k;
    logic [Aw-1:0]           wr_ptr;
    logic [Aw-1:0]           base;
    logic [Aw-1:0]           rd_addr;
    logic signed [Win-1:0]   sample_q;
    logic                    acc_en;
    logic signed [Win+Wc-1:0] prod;
    logic signed [Wacc-1:0]  prod_ext;
    logic signed [Wacc-1:0]  acc;

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus handshake and ROM address outputs.
    always_comb begin
        state_next = state;
        din_ready  = 1'b0;
        coef_addr  = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    accept     = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                coef_addr = k;
                if (k == LAST_TAP) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Tap counter, write pointer and the newest-sample position latched at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            k      <= '0;
            wr_ptr <= '0;
            base   <= '0;
        end else if (accept) begin
            base   <= wr_ptr;
            wr_ptr <= (wr_ptr == LAST_TAP) ? '0 : wr_ptr + 1'b1;
            k      <= '0;
        end else if (state == MAC) begin
            k <= (k == LAST_TAP) ? '0 : k + 1'b1;
        end
    end

    // x[n-k] lives at (base - k) mod Num_coef; adding the tap count first keeps
    // the arithmetic inside Aw bits, and for power-of-two depths N_TAPS wraps to
    // zero so the plain modular subtract falls out.
    always_comb begin
        rd_addr = (k > base) ? base + (N_TAPS - k) : base - k;
    end

    fir_delay_line #(
        .Num_coef (Num_coef),
        .Win      (Win)
    ) u_delay_line (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_addr (rd_addr),
        .rd_data (sample_q)
    );

    // Full-precision signed product, sign-extended to the accumulator width.
    always_comb begin
        prod     = (Win+Wc)'(sample_q) * (Win+Wc)'(coef_data);
        prod_ext = Wacc'(prod);
    end

    // Accumulate enable trails MAC by one cycle to match the registered operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_en <= 1'b0;
        end else begin
            acc_en <= (state == MAC);
        end
    end

    // Accumulator and output register; the last product goes straight into dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (accept) begin
                acc <= '0;
            end else if (acc_en) begin
                acc <= acc + prod_ext;
            end
            if (state == FLUSH) begin
                dout       <= acc + prod_ext;
                dout_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fir_serial_mac.md
# fir_serial_mac

Time-multiplexed single-MAC FIR filter engine that consumes the coefficient ROM: it drives the ROM address, reads one coefficient per cycle, multiplies it by the matching delayed input sample and accumulates a full-precision output. It sits between the sample source (valid-qualified input) and the output stage, and owns the sample delay line. One output is produced per accepted input sample.

## Interface
- Num_coef, 17, number of taps; must equal the ROM depth
- Wc, 18, coefficient width, signed
- Win, 16, input sample width, signed
- Wacc, Win+Wc+log2(Num_coef) (=39), accumulator/output width; derived, not overridden
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- din_valid  in  1  input sample strobe
- din  in  Win  signed input sample
- din_ready  out  1  high when a sample can be accepted (state IDLE)
- coef_addr  out  log2(Num_coef)  ROM address
- coef_data  in  Wc  signed ROM data, registered in the ROM (1-cycle latency)
- dout  out  Wacc  signed filter output y[n] = sum h[k]·x[n-k]
- dout_valid  out  1  one-cycle pulse when dout is updated

## Operation
- FSM states: IDLE, MAC, FLUSH.
- IDLE: din_ready=1. din_valid=1 accepted at edge E0: sample written to delay line at wr_ptr, wr_ptr advances mod Num_coef (wraps 16→0), k←0, acc←0, state←MAC.
- MAC: coef_addr=k, delay-line read address = (wr_ptr_at_accept − k) mod Num_coef; read sample registered so it aligns with coef_data. k increments each cycle; after k=Num_coef−1 state←FLUSH.
- Accumulate: one-cycle-delayed enable; acc ← acc + coef_data·sample_q, signed full-precision product (Win+Wc bits) sign-extended to Wacc. Wacc guarantees no overflow; no saturation, no rounding.
- FLUSH: final product added; at that edge dout ← acc + product, dout_valid←1, state←IDLE.
- din_valid while din_ready=0: sample dropped, no state change.
- Delay line holds Num_coef samples; initial content zero.
- Reset (any state, including mid-MAC): state IDLE, k=0, wr_ptr=0, acc=0, delay line all zero, coef_addr=0, dout=0, dout_valid=0, din_ready=1. Partial result discarded, no dout_valid.

## Timing
- Acceptance edge E0 → dout_valid high exactly Num_coef+1 edges later (E18), for one cycle.
- dout holds its value until next dout_valid.
- din_ready low from E0 to E18; next acceptance earliest at E19: sustained throughput one sample per Num_coef+2 cycles (19).
- coef_addr sequence during MAC: 0,1,…,Num_coef−1; holds 0 in IDLE/FLUSH.
- Product term k is added at edge E(k+2).

## Structure
- Shared package fir_pkg: log2 function (ceil, as used for address widths), default Num_coef/Wc/Win, Wacc derivation, FSM state encoding.
- One sub-module: fir_delay_line (circular register buffer, Num_coef×Win, one write port, one registered read port, synchronous clear on rst).
- ROM instantiated alongside at top level, not inside this block.

## Test plan
- Impulse: din=1 then 16 zeros, real ROM → dout sequence equals h[0]…h[16], then 0 on further zero inputs.
- Step: din=1 for 30 samples → dout ramps by h[k] and settles at sum(h) from 17th output onward.
- Extremes: din=−32768 for 17 samples, then +32767 → dout matches 39-bit reference model bit-exact, no wrap.
- Latency/handshake: assert din_valid continuously → accepts spaced 19 cycles, dout_valid exactly 18 edges after each accept; samples offered while din_ready=0 absent from output.
- Reset mid-MAC: rst for 1 cycle at k=8 → no dout_valid, dout=0, din_ready=1 next cycle; following impulse yields h[0] (delay line cleared).
- Pointer wrap: 40 random samples → all outputs match model across wr_ptr wraparound.
